ext_obi_responder: RTL and testbench
====================================

EXT_OBI_RESPONDER -- requirements
Module: ext_obi_responder

Interface
REQ-001: Parameter NumWords, default 32'd256, number of 32-bit words in the scratchpad; SHALL be a power of two, at least 2.
REQ-002: Parameter WaitCycles, default 32'd0, number of extra cycles between grant and response; SHALL be in the range 0..15.
REQ-003: Parameter OorRdata, default 32'hBADCAB1E, read data returned for out-of-range addresses.
REQ-004: clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005: rst_i  input  1  synchronous, active-high reset.
REQ-006: req_i  input  1  OBI request from an external-bus master.
REQ-007: gnt_o  output  1  OBI grant.
REQ-008: addr_i  input  32  byte address; word index is addr_i[$clog2(NumWords)+1:2].
REQ-009: we_i  input  1  1 = write, 0 = read.
REQ-010: be_i  input  4  byte enables.
REQ-011: wdata_i  input  32  write data.
REQ-012: rvalid_o  output  1  OBI response valid, one-cycle pulse.
REQ-013: rdata_o  output  32  OBI read data, qualified by rvalid_o.
REQ-014: busy_o  output  1  high while a granted transaction has not yet responded.

Function
REQ-015: The block SHALL act as an OBI slave with at most one outstanding transaction and no response backpressure.
REQ-016: The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-017: gnt_o SHALL equal req_i combinationally in IDLE and RESP, and SHALL be 0 in WAIT and whenever rst_i=1.
REQ-018: A handshake is req_i & gnt_o sampled at a rising edge; at that edge the block SHALL latch we_i and the word index.
REQ-019: A handshake with WaitCycles=0 SHALL go to RESP; with WaitCycles>0 it SHALL go to WAIT and load the wait counter with WaitCycles-1.
REQ-020: WAIT SHALL decrement the counter each cycle and go to RESP on the edge where the counter is 0.
REQ-021: rvalid_o SHALL be 1 exactly in RESP, i.e. WaitCycles+1 cycles after the handshake edge.
REQ-022: In RESP, a new handshake SHALL go to RESP or WAIT per REQ-019; with no handshake the FSM SHALL return to IDLE. This gives throughput of 1 transaction/cycle when WaitCycles=0.
REQ-023: An in-range write SHALL update only the bytes whose be_i bit is set, at the handshake edge.
REQ-024: be_i=4'b0000 on a write SHALL leave memory unchanged and still produce a response.
REQ-025: A read SHALL capture mem[index] into the rdata register at the handshake edge, and rdata_o SHALL hold that value through RESP.
REQ-026: A read whose handshake edge coincides with a write to the same word SHALL return the pre-write data.
REQ-027: A read issued after a completed write to the same word SHALL return the new data.
REQ-028: A write response SHALL drive rdata_o=32'h0.
REQ-029: An address with any bit above bit $clog2(NumWords)+1 set is out of range: writes SHALL be ignored and reads SHALL return OorRdata, with normal response timing.
REQ-030: addr_i[1:0] SHALL be ignored.
REQ-031: busy_o SHALL be 1 in WAIT, and in RESP only if no new handshake occurs that cycle; otherwise it SHALL be 0.
REQ-032: Inputs other than req_i SHALL be ignored outside the handshake edge.

Reset
REQ-033: While rst_i=1 at a rising edge, the block SHALL enter IDLE, clear the wait counter, and set rvalid_o=0, rdata_o=32'h0 and busy_o=0.
REQ-034: Scratchpad contents SHALL NOT be cleared by reset.
REQ-035: Reset asserted mid-transaction SHALL abort it with no rvalid_o, while a write already committed at its handshake edge SHALL persist.
REQ-036: The first handshake after reset deassertion SHALL be accepted in the first cycle with rst_i=0.

Verification
REQ-037: WaitCycles=0: write 0x1234_5678 to 0x10 with be=4'hF, then read 0x10 -> rvalid_o one cycle after each grant, read returns 0x1234_5678.
REQ-038: Partial write: be=4'b0010 with wdata 0xAAAA_BBCC over 0x1234_5678 -> subsequent read returns 0x1234_BB78.
REQ-039: WaitCycles=3: req_i held high -> gnt_o pulses every 4 cycles, rvalid_o 4 cycles after each grant, busy_o high in between.
REQ-040: Read at 0x0000_1000 with NumWords=256 -> rdata_o=0xBADCAB1E; a write to that address leaves all in-range words unchanged.
REQ-041: WaitCycles=0, back-to-back write 0x5 then read to word 0 on consecutive edges -> read returns 0x5 and rvalid_o stays high for 2 cycles.
REQ-042: WaitCycles=3: assert rst_i during WAIT after a write -> no rvalid_o, gnt_o=0 during reset, a later read returns the written data.

Source files
------------

// File: rtl/ext_obi_responder.sv
// ext_obi_responder
//   OBI slave fronting a word-addressed scratchpad for an external-bus
//   master. It has at most one outstanding transaction, an optional fixed
//   response latency and no response backpressure.
//
// Parameters
//   NumWords   : scratchpad depth in 32-bit words (power of two, >= 2)
//   WaitCycles : extra cycles between grant and response (0..15)
//   OorRdata   : read data returned for out-of-range addresses
//
// Ports
//   clk_i    : clock, all state updates on the rising edge
//   rst_i    : synchronous active-high reset
//   req_i    : OBI request
//   gnt_o    : OBI grant (combinational from req_i when able to accept)
//   addr_i   : byte address, word index is addr_i[$clog2(NumWords)+1:2]
//   we_i     : 1 = write, 0 = read
//   be_i     : byte enables for writes
//   wdata_i  : write data
//   rvalid_o : one-cycle response pulse
//   rdata_o  : read data (32'h0 for write responses), qualified by rvalid_o
//   busy_o   : a granted transaction has not yet responded
module ext_obi_responder #(
  parameter int unsigned NumWords   = 32'd256,
  parameter int unsigned WaitCycles = 32'd0,
  parameter logic [31:0] OorRdata   = 32'hBADCAB1E
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        busy_o
);

  localparam int unsigned IdxW = $clog2(NumWords);
  // The counter is loaded with WaitCycles-1 so that WAIT lasts exactly
  // WaitCycles cycles; the guard keeps the constant legal when WaitCycles=0.
  localparam logic [3:0] WaitLoad = (WaitCycles > 0) ? 4'(WaitCycles - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [31:0]     rdata_q;
  logic [31:0]     mem [NumWords];
  logic            hs;
  logic            in_range;
  logic [IdxW-1:0] idx;

  assign idx      = addr_i[IdxW+1:2];
  // Any address bit above the word index makes the access out of range;
  // addr_i[1:0] drops out of the shift and is therefore ignored.
  assign in_range = (addr_i >> (IdxW + 2)) == 32'd0;

  // NOTE: every signal written here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_o   = 1'b0;

    // Grant is withheld only while waiting out the response latency.
    if (state_q != WAIT) begin
      gnt_o = req_i & ~rst_i;
    end
    hs = req_i & gnt_o;

    unique case (state_q)
      IDLE, RESP: begin
        if (hs) begin
          state_d = (WaitCycles == 0) ? RESP : WAIT;
          cnt_d   = WaitLoad;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments make a read at the handshake edge see
  // the memory word as it was before any write committed on that edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Response data is fixed at the handshake edge, so address and data
      // inputs are free to change while the transaction is in flight.
      if (hs) begin
        if (we_i) begin
          rdata_q <= 32'h0;
        end else if (in_range) begin
          rdata_q <= mem[idx];
        end else begin
          rdata_q <= OorRdata;
        end
      end
    end
  end

  // NOTE: the scratchpad is deliberately not reset; its contents survive
  // rst_i, and hs is already forced low while rst_i is high.
  always_ff @(posedge clk_i) begin
    if (hs && we_i && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem[idx][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rvalid_o = (state_q == RESP);
  assign rdata_o  = rdata_q;
  // A back-to-back handshake in RESP starts a new transaction rather than
  // leaving one pending, so busy_o drops for that cycle.
  assign busy_o   = (state_q == WAIT) || ((state_q == RESP) && !hs);

endmodule

// File: tb/tb_ext_obi_responder.sv
// tb_ext_obi_responder
//   Two instances share one clock and reset: index 0 runs with WaitCycles=0,
//   index 1 with WaitCycles=3. A transaction-level model predicts grant,
//   response timing, busy and read data from the handshake history and a
//   model copy of each scratchpad. Directed sequences cover the worked
//   examples, followed by a randomized phase.
module tb_ext_obi_responder;

  localparam int unsigned NumWords = 256;
  localparam logic [31:0] Oor      = 32'hBADCAB1E;
  localparam int unsigned Wait0    = 0;
  localparam int unsigned Wait1    = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req    [2];
  logic        we     [2];
  logic [3:0]  be     [2];
  logic [31:0] addr   [2];
  logic [31:0] wdata  [2];
  logic        gnt    [2];
  logic        rvalid [2];
  logic [31:0] rdata  [2];
  logic        busy   [2];

  always #5 clk = ~clk;

  ext_obi_responder #(.NumWords(NumWords), .WaitCycles(Wait0), .OorRdata(Oor)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr[0]),
    .we_i(we[0]), .be_i(be[0]), .wdata_i(wdata[0]), .rvalid_o(rvalid[0]),
    .rdata_o(rdata[0]), .busy_o(busy[0])
  );

  ext_obi_responder #(.NumWords(NumWords), .WaitCycles(Wait1), .OorRdata(Oor)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr[1]),
    .we_i(we[1]), .be_i(be[1]), .wdata_i(wdata[1]), .rvalid_o(rvalid[1]),
    .rdata_o(rdata[1]), .busy_o(busy[1])
  );

  // Reference model: per-instance memory, whether a transaction is pending,
  // the cycle number in which its response is due, and its response data.
  logic [31:0] ref_mem   [2][NumWords];
  bit          pending   [2];
  int unsigned due       [2];
  logic [31:0] ref_rdata [2];
  bit          last_hs   [2];
  int unsigned cyc;

  int total;
  int bad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input int k, input bit r, input bit w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d);
    req[k]   = r;
    we[k]    = w;
    be[k]    = b;
    addr[k]  = a;
    wdata[k] = d;
  endtask

  // One clock cycle: check outputs mid-cycle against the model, advance the
  // model across the coming edge, then return just after that edge.
  task automatic step();
    bit          in_wait, in_resp, g, inr;
    int unsigned w, widx;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      w       = (k == 0) ? Wait0 : Wait1;
      in_wait = pending[k] && (cyc < due[k]);
      in_resp = pending[k] && (cyc == due[k]);
      g       = req[k] && !rst && !in_wait;
      check($sformatf("gnt%0d@%0d", k, cyc), 32'(gnt[k]), 32'(g));
      check($sformatf("rvalid%0d@%0d", k, cyc), 32'(rvalid[k]), 32'(in_resp));
      check($sformatf("busy%0d@%0d", k, cyc), 32'(busy[k]), 32'(in_wait || (in_resp && !g)));
      if (in_resp) begin
        check($sformatf("rdata%0d@%0d", k, cyc), rdata[k], ref_rdata[k]);
      end
      last_hs[k] = g;
      if (rst) begin
        pending[k]   = 1'b0;
        ref_rdata[k] = 32'h0;
      end else if (g) begin
        inr  = addr[k] < NumWords * 4;
        widx = (addr[k] / 4) % NumWords;
        if (we[k]) begin
          ref_rdata[k] = 32'h0;
          if (inr) begin
            for (int b = 0; b < 4; b++) begin
              if (be[k][b]) ref_mem[k][widx][8*b +: 8] = wdata[k][8*b +: 8];
            end
          end
        end else begin
          ref_rdata[k] = inr ? ref_mem[k][widx] : Oor;
        end
        pending[k] = 1'b1;
        due[k]     = cyc + 1 + w;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_steps(input int n);
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int unsigned fill [2];
    int          n_gnt, n_busy, n_rvalid;
    logic [31:0] a;

    total = 0;
    bad   = 0;
    cyc   = 0;
    for (int k = 0; k < 2; k++) begin
      pending[k]   = 1'b0;
      due[k]       = 0;
      ref_rdata[k] = 32'h0;
      last_hs[k]   = 1'b0;
      // Request held during reset: grant must still stay low.
      drive(k, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
    end

    rst = 1'b1;
    step();
    step();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_rvalid%0d", k), 32'(rvalid[k]), 32'h0);
      check($sformatf("rst_busy%0d", k), 32'(busy[k]), 32'h0);
      check($sformatf("rst_rdata%0d", k), rdata[k], 32'h0);
    end
    rst = 1'b0;

    // Preload every word of both scratchpads so later reads are predictable.
    fill[0] = 0;
    fill[1] = 0;
    for (int n = 0; n < 3000 && (fill[0] < NumWords || fill[1] < NumWords); n++) begin
      for (int k = 0; k < 2; k++) begin
        if (fill[k] < NumWords) drive(k, 1'b1, 1'b1, 4'hF, fill[k] * 4 + $urandom_range(0, 3), $urandom);
        else                    drive(k, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      end
      step();
      for (int k = 0; k < 2; k++) if (last_hs[k] && fill[k] < NumWords) fill[k]++;
    end
    check("preload_done0", fill[0], NumWords);
    check("preload_done1", fill[1], NumWords);
    idle_steps(6);

    // Full write then read, zero wait: one cycle from grant to response.
    drive(0, 1'b1, 1'b1, 4'hF, 32'h10, 32'h1234_5678);
    step();
    check("wr_resp_rvalid", 32'(rvalid[0]), 32'h1);
    check("wr_resp_rdata", rdata[0], 32'h0);
    drive(0, 1'b1, 1'b0, 4'hF, 32'h10, 32'hFFFF_FFFF);
    step();
    check("rd_resp_rvalid", 32'(rvalid[0]), 32'h1);
    check("rd_full_word", rdata[0], 32'h1234_5678);
    // Partial write of byte 1 only; read with nonzero addr[1:0].
    drive(0, 1'b1, 1'b1, 4'b0010, 32'h10, 32'hAAAA_BBCC);
    step();
    drive(0, 1'b1, 1'b0, 4'hF, 32'h12, 32'h0);
    step();
    check("rd_partial", rdata[0], 32'h1234_BB78);
    // Write with no byte enables still responds and changes nothing.
    drive(0, 1'b1, 1'b1, 4'b0000, 32'h10, 32'hFFFF_FFFF);
    step();
    check("be0_rvalid", 32'(rvalid[0]), 32'h1);
    drive(0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    step();
    check("be0_unchanged", rdata[0], 32'h1234_BB78);
    // Back-to-back write then read of word 0.
    drive(0, 1'b1, 1'b1, 4'hF, 32'h3, 32'h5);
    step();
    check("b2b_rvalid_wr", 32'(rvalid[0]), 32'h1);
    drive(0, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
    step();
    check("b2b_rvalid_rd", 32'(rvalid[0]), 32'h1);
    check("b2b_rdata", rdata[0], 32'h5);
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step();
    check("b2b_rvalid_end", 32'(rvalid[0]), 32'h0);

    // Out-of-range write, then sweep every word: the model flags any change.
    drive(0, 1'b1, 1'b1, 4'hF, 32'h1000, 32'hDEAD_BEEF);
    step();
    for (int i = 0; i < NumWords; i++) begin
      drive(0, 1'b1, 1'b0, 4'hF, i * 4, 32'h0);
      step();
    end
    idle_steps(2);

    // Out-of-range read with three wait cycles.
    drive(1, 1'b1, 1'b0, 4'hF, 32'h1000, 32'h0);
    step();
    drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step();
    step();
    check("oor_not_yet", 32'(rvalid[1]), 32'h0);
    step();
    check("oor_rvalid", 32'(rvalid[1]), 32'h1);
    check("oor_rdata", rdata[1], Oor);
    idle_steps(4);

    // Request held high with three wait cycles: one grant every 4 cycles.
    n_gnt    = 0;
    n_busy   = 0;
    n_rvalid = 0;
    drive(1, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
    for (int i = 0; i < 12; i++) begin
      #1;
      n_gnt    += int'(gnt[1]);
      n_busy   += int'(busy[1]);
      n_rvalid += int'(rvalid[1]);
      step();
    end
    check("held_gnt_count", n_gnt, 3);
    check("held_busy_count", n_busy, 9);
    check("held_rvalid_count", n_rvalid, 2);
    idle_steps(6);

    // Reset during WAIT after a write: no response, write persists.
    drive(1, 1'b1, 1'b1, 4'hF, 32'h40, 32'hCAFE_F00D);
    step();
    drive(1, 1'b1, 1'b0, 4'hF, 32'h80, 32'h0);
    step();
    rst = 1'b1;
    #1;
    check("rst_mid_gnt", 32'(gnt[1]), 32'h0);
    step();
    check("rst_mid_rvalid", 32'(rvalid[1]), 32'h0);
    check("rst_mid_busy", 32'(busy[1]), 32'h0);
    rst = 1'b0;
    drive(1, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
    #1;
    check("gnt_after_rst", 32'(gnt[1]), 32'h1);
    step();
    drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step();
    step();
    step();
    check("rst_write_kept", rdata[1], 32'hCAFE_F00D);
    idle_steps(4);

    // Randomized phase: a few hot words, odd low address bits, occasional
    // out-of-range addresses and sporadic resets.
    for (int n = 0; n < 2500; n++) begin
      rst = ($urandom_range(0, 149) == 0);
      for (int k = 0; k < 2; k++) begin
        case ($urandom_range(0, 7))
          0:       a = $urandom | 32'h8000_0000;
          1:       a = NumWords * 4 + $urandom_range(0, 3);
          default: a = $urandom_range(0, 7) * 4 + $urandom_range(0, 3);
        endcase
        drive(k, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
              4'($urandom), a, $urandom);
      end
      step();
    end
    rst = 1'b0;
    idle_steps(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
